// File: rtl/writeback_stage_pkg.sv
// Shared constants and types for the writeback stage: machine width,
// register count and register-index type.
package writeback_stage_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t X0 = 5'd0;

endpackage

// File: rtl/writeback_stage_if.sv
// Execute/dispatch-facing bus of the writeback stage: completion, flush,
// issue, the two register read ports and the architectural status outputs.
interface writeback_stage_if;
  import writeback_stage_pkg::*;

  logic            kill;
  logic [XLEN-1:0] redirect_pc;
  logic            complete_valid;
  reg_idx_t        complete_rd;
  logic [XLEN-1:0] complete_data;
  logic [XLEN-1:0] nextpc;
  logic            issue_valid;
  reg_idx_t        issue_rd;
  reg_idx_t        rs1_addr;
  reg_idx_t        rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [NREG-1:0] busy;
  logic [XLEN-1:0] committed_pc;
  logic [63:0]     instret;

  modport master (
    output kill, redirect_pc, complete_valid, complete_rd, complete_data, nextpc,
           issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, busy, committed_pc, instret
  );

  modport slave (
    input  kill, redirect_pc, complete_valid, complete_rd, complete_data, nextpc,
           issue_valid, issue_rd, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, busy, committed_pc, instret
  );

endinterface

// File: rtl/writeback_stage_regfile_2r1w.sv
// Architectural integer register file: one write port, two combinational
// read ports that bypass the same-cycle write, x0 reads as zero.
module regfile_2r1w
  import writeback_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  reg_idx_t        waddr,
  input  logic [XLEN-1:0] wdata,
  input  reg_idx_t        raddr1,
  input  reg_idx_t        raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [NREG];

  // NOTE: the array is reset element by element because software may read
  // registers before writing them; this costs a reset mux per flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != X0) begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      mem[waddr] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input reg_idx_t addr,
                                                input logic we_i,
                                                input reg_idx_t waddr_i,
                                                input logic [XLEN-1:0] wdata_i,
                                                input logic [XLEN-1:0] stored);
    if (addr == X0)                  return '0;
    else if (we_i && waddr_i == addr) return wdata_i;
    else                             return stored;
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1, we, waddr, wdata, mem[raddr1]);
    rdata2 = read_port(raddr2, we, waddr, wdata, mem[raddr2]);
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires execute completions into the register file,
// tracks committed PC, retired-instruction count and the busy scoreboard.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  writeback_stage_if.slave wb
);

  logic            retire;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [XLEN-1:0] pc_q;
  logic [63:0]     instret_q;

  // A flush discards the completion arriving in the same cycle.
  assign retire = wb.complete_valid & ~wb.kill;

  regfile_2r1w u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (retire),
    .waddr  (wb.complete_rd),
    .wdata  (wb.complete_data),
    .raddr1 (wb.rs1_addr),
    .raddr2 (wb.rs2_addr),
    .rdata1 (wb.rs1_data),
    .rdata2 (wb.rs2_data)
  );

  // NOTE: busy_d starts from a full default so no path leaves it unassigned.
  always_comb begin
    busy_d = busy_q;
    if (wb.kill) begin
      busy_d = '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        // A same-cycle issue is younger than the retiring result, so set wins.
        if (wb.issue_valid && wb.issue_rd == reg_idx_t'(i))
          busy_d[i] = 1'b1;
        else if (retire && wb.complete_rd == reg_idx_t'(i))
          busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      pc_q      <= RESET_PC;
      instret_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (wb.kill) begin
        pc_q <= wb.redirect_pc;
      end else if (retire) begin
        pc_q      <= wb.nextpc;
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign wb.busy         = busy_q;
  assign wb.committed_pc = pc_q;
  assign wb.instret      = instret_q;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Stage directly downstream of the execute stage. It consumes the per-cycle completion result (destination register, data, next PC) and holds the architectural state: the 32x32 integer register file, the committed program counter, a busy scoreboard and a 64-bit retired-instruction counter. It also gives dispatch two combinational register read ports with same-cycle bypass, plus a busy vector for issue gating.

Parameters:
XLEN, 32, data and PC width
NREG, 32, number of architectural registers; x0 is hardwired to zero
RESET_PC, 32'h0000_0000, value loaded into committed_pc on reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
kill  in  1  flush: drop the same-cycle completion, clear the scoreboard, load redirect_pc
redirect_pc  in  XLEN  PC loaded on kill
complete_valid  in  1  execute produced a result this cycle
complete_rd  in  5  destination register of the completion
complete_data  in  XLEN  result data
nextpc  in  XLEN  PC following the completing instruction
issue_valid  in  1  dispatch issues an instruction this cycle
issue_rd  in  5  destination register of the issued instruction
rs1_addr, rs2_addr  in  5 each  read addresses
rs1_data, rs2_data  out  XLEN each  read data (combinational)
busy  out  NREG  scoreboard; bit i set = register i has a write pending
committed_pc  out  XLEN  PC of the next instruction to retire
instret  out  64  count of retired instructions

Behaviour:
- Reset (synchronous, on clk when reset=1): all registers to 0, busy=0, committed_pc=RESET_PC, instret=0. reset overrides kill and every other input.
- Retire condition: retire = complete_valid & ~kill.
- On retire:
  - if complete_rd != 0, write regfile[complete_rd] <= complete_data;
  - committed_pc <= nextpc;
  - instret <= instret+1. instret wraps modulo 2^64 with no saturation.
  - A completion with rd=0 still retires: PC and instret update, no register write.
- Write latency: the value is visible in the array on the next cycle. The bypass below makes it visible the same cycle.
- Read ports:
  - addr=0 returns 0;
  - else if retire and complete_rd==addr, returns complete_data (bypass);
  - else returns regfile[addr].
  - Purely combinational; no registered outputs.
- Scoreboard, per bit i != 0, priority kill > set > clear:
  - kill: busy <= 0 (all in-flight results are discarded);
  - issue_valid & issue_rd==i: busy[i] <= 1, even if a completion to i retires in the same cycle, because the new issue is younger;
  - retire & complete_rd==i: busy[i] <= 0;
  - busy[0] is always 0.
- Kill: committed_pc <= redirect_pc, no register write, instret unchanged, issue_valid in the same cycle is ignored.
- Dispatch is responsible for not issuing while busy[rs1|rs2|rd] is set. This block does not check it: duplicate sets are idempotent, and a clear of a non-busy bit is harmless.
- One completion and one issue per cycle at most; no internal buffering; no backpressure output.

Decomposition:
- Shared package (alongside the existing constants include): XLEN, NREG, register-index type (5 bits), and the x0 index constant.
- One natural sub-module: regfile_2r1w. It holds the NREG x XLEN array with synchronous reset, two combinational read ports with write bypass, x0 forced to zero, and one write port (we, waddr, wdata).
- The scoreboard, PC and instret logic live in writeback_stage.

Test Plan:
- Reset then idle 3 cycles -> committed_pc=RESET_PC, instret=0, busy=0, rs1_data=rs2_data=0 for all addresses.
- issue rd=5; next cycle complete rd=5 data=0xDEADBEEF nextpc=0x104 -> busy[5]=1 after issue. In the completion cycle rs1_addr=5 reads 0xDEADBEEF (bypass). Next cycle busy[5]=0, committed_pc=0x104, instret=1.
- complete rd=0 data=0x1234 nextpc=0x8 -> rs1_addr=0 reads 0, committed_pc=0x8, instret increments, busy[0] stays 0.
- Same cycle: complete rd=7 and issue rd=7 -> register 7 updated, busy[7]=1 afterward.
- issue rd=3 and rd=9 in two cycles; then kill with redirect_pc=0x200 and complete_valid=1 rd=3 data=0x55 -> busy=0, committed_pc=0x200, x3 unchanged, instret unchanged.
- Preload instret near wrap via 2^64-1 retirements (force/backdoor), then one completion -> instret=0. Assert reset mid-stream with complete_valid=1 -> all state at reset values the next cycle.
